sd_receiver: RTL and testbench

SD_RECEIVER -- requirements
Module: sd_receiver

---
 rtl/sd_pkg.sv | 6 +
 rtl/sd_receiver.sv | 76 +++++++
 tb/tb_sd_receiver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding and default configuration for the serial receiver
package sd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, CHECK} state_t;
  localparam int SD_WIDTH = 14;
  localparam int SD_ODD_PARITY = 1;
endpackage

// File: rtl/sd_receiver.sv
// sd_receiver: strobe-sampled serial word receiver with parity, overrun and framing checks
module sd_receiver
  import sd_pkg::*;
#(
  parameter int WIDTH = SD_WIDTH,
  parameter int ODD_PARITY = SD_ODD_PARITY
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             DATA,
  input  logic             SAMP,
  input  logic             WSTART,
  input  logic             WACK,
  input  logic             ERRCLR,
  output logic [WIDTH-1:0] WORD,
  output logic             WVALID,
  output logic             BUSY,
  output logic             PERR,
  output logic             OVRN,
  output logic             FRERR
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic ODD = ODD_PARITY != 0;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic par, shift_en, par_en, chk, good, load;
  assign shift_en = state == SHIFT && SAMP && !WSTART;
  assign par_en = state == PAR && SAMP && !WSTART;
  assign chk = state == CHECK;
  assign good = par == ODD;
  assign load = chk && good && (!WVALID || WACK);
  // state register
  always_ff @(posedge SIM_CLK or posedge SIM_RST)
    if (SIM_RST) state <= IDLE;
    else state <= state_nxt;
  // next state: a word start always (re)enters SHIFT, otherwise strobes advance the frame
  always_comb
    state_nxt = WSTART ? SHIFT :
                shift_en && cnt == LAST ? PAR :
                par_en ? CHECK :
                chk ? IDLE : state;
  // outputs decoded from state
  always_comb BUSY = state != IDLE;
  // bit capture: counter, shift register and running parity, cleared on every word start
  always_ff @(posedge SIM_CLK or posedge SIM_RST)
    if (SIM_RST) begin
      cnt <= '0;
      sreg <= '0;
      par <= 1'b0;
    end else if (WSTART) begin
      cnt <= '0;
      sreg <= '0;
      par <= 1'b0;
    end else if (shift_en) begin
      cnt <= cnt + CW'(1);
      sreg <= {sreg[WIDTH-2:0], DATA};
      par <= par ^ DATA;
    end else if (par_en) par <= par ^ DATA;
  // word hand-off and sticky errors; a newly detected error beats a same-cycle clear
  always_ff @(posedge SIM_CLK or posedge SIM_RST)
    if (SIM_RST) begin
      WORD <= '0;
      WVALID <= 1'b0;
      PERR <= 1'b0;
      OVRN <= 1'b0;
      FRERR <= 1'b0;
    end else begin
      if (load) WORD <= sreg;
      WVALID <= load || (WVALID && !WACK);
      PERR <= (chk && !good) || (PERR && !ERRCLR);
      OVRN <= (chk && good && WVALID && !WACK) || (OVRN && !ERRCLR);
      FRERR <= (WSTART && (state == SHIFT || state == PAR)) || (FRERR && !ERRCLR);
    end
endmodule

// File: tb/tb_sd_receiver.sv
// tb_sd_receiver: randomized word-level checks of sd_receiver against a behavioural model
module tb_sd_receiver;
  localparam int W = 14;
  localparam int ODD = 1;
  logic SIM_CLK = 1'b0, SIM_RST = 1'b1;
  logic DATA = 1'b0, SAMP = 1'b0, WSTART = 1'b0, WACK = 1'b0, ERRCLR = 1'b0;
  logic [W-1:0] WORD;
  logic WVALID, BUSY, PERR, OVRN, FRERR;
  logic [W+4:0] obs;
  logic [W-1:0] m_word;
  logic m_wv, m_perr, m_ovrn, m_frerr;
  int n_cmp = 0, n_bad = 0;

  sd_receiver #(.WIDTH(W), .ODD_PARITY(ODD)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .DATA(DATA), .SAMP(SAMP), .WSTART(WSTART),
    .WACK(WACK), .ERRCLR(ERRCLR), .WORD(WORD), .WVALID(WVALID), .BUSY(BUSY),
    .PERR(PERR), .OVRN(OVRN), .FRERR(FRERR)
  );

  always #5 SIM_CLK = ~SIM_CLK;
  assign obs = {WORD, WVALID, BUSY, PERR, OVRN, FRERR};

  function automatic logic [W+4:0] expv(input logic busy);
    return {m_word, m_wv, busy, m_perr, m_ovrn, m_frerr};
  endfunction

  task automatic model_clear;
    m_word = '0; m_wv = 0; m_perr = 0; m_ovrn = 0; m_frerr = 0;
  endtask

  task automatic cyc(input logic ws, sp, d, ack, clr);
    WSTART = ws; SAMP = sp; DATA = d; WACK = ack; ERRCLR = clr;
    @(posedge SIM_CLK); #1;
    WSTART = 0; SAMP = 0; DATA = 0; WACK = 0; ERRCLR = 0;
  endtask

  task automatic do_reset;
    SIM_RST = 1;
    @(posedge SIM_CLK); #1;
    SIM_RST = 0;
    model_clear();
  endtask

  // optional start, WIDTH data strobes MSB first, then the parity strobe, with random idle gaps
  task automatic send_bits(input logic [W-1:0] data, input logic p, input logic start, input int maxgap);
    if (start) cyc(1, 0, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      repeat ($urandom_range(maxgap, 0)) cyc(0, 0, 1'($urandom), 0, 0);
      cyc(0, 1, data[i], 0, 0);
    end
    repeat ($urandom_range(maxgap, 0)) cyc(0, 0, 1'($urandom), 0, 0);
    cyc(0, 1, p, 0, 0);
  endtask

  // the cycle after the parity strobe, plus the word-level outcome in the model
  task automatic finish_check(input logic [W-1:0] data, input logic p, input logic ack, clr, ws);
    logic good;
    cyc(ws, 0, 0, ack, clr);
    good = (($countones(data) + int'(p)) % 2) == ODD;
    if (clr) begin m_perr = 0; m_ovrn = 0; m_frerr = 0; end
    if (good) begin
      if (!m_wv || ack) begin m_word = data; m_wv = 1; end
      else m_ovrn = 1;
    end else begin
      m_perr = 1;
      if (ack) m_wv = 0;
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_async: got %h expected %h", obs, '0); end
    do_reset();
    repeat (3) cyc(0, 1, 1, 0, 0);
    n_cmp++; if (obs !== expv(0)) begin n_bad++; $display("FAIL idle_samp_ignored: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_good_word;
    do_reset();
    send_bits(14'h2CE5, 1, 1, 0);
    n_cmp++; if ({WVALID, BUSY} !== 2'b01) begin n_bad++; $display("FAIL good_latency1: got %b expected 01", {WVALID, BUSY}); end
    finish_check(14'h2CE5, 1, 0, 0, 0);
    n_cmp++; if (obs !== expv(0) || WORD !== 14'h2CE5) begin n_bad++; $display("FAIL good_word: got %h expected %h", obs, expv(0)); end
    cyc(0, 0, 0, 1, 0); m_wv = 0;
    n_cmp++; if (obs !== expv(0)) begin n_bad++; $display("FAIL good_ack: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_bad_parity;
    do_reset();
    send_bits(14'h2CE5, 0, 1, 1);
    finish_check(14'h2CE5, 0, 0, 0, 0);
    n_cmp++; if (obs !== expv(0) || PERR !== 1'b1) begin n_bad++; $display("FAIL bad_parity: got %h expected %h", obs, expv(0)); end
    send_bits(14'h0F0F, 0, 1, 0);
    finish_check(14'h0F0F, 0, 0, 1, 0);
    n_cmp++; if (obs !== expv(0) || PERR !== 1'b1) begin n_bad++; $display("FAIL perr_beats_clr: got %h expected %h", obs, expv(0)); end
    cyc(0, 0, 0, 0, 1); m_perr = 0;
    n_cmp++; if (obs !== expv(0)) begin n_bad++; $display("FAIL errclr: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_overrun;
    do_reset();
    send_bits(14'h2CE5, 1, 1, 0); finish_check(14'h2CE5, 1, 0, 0, 0);
    send_bits(14'h0001, 0, 1, 0); finish_check(14'h0001, 0, 0, 0, 0);
    n_cmp++; if (obs !== expv(0) || WORD !== 14'h2CE5 || OVRN !== 1'b1) begin n_bad++; $display("FAIL overrun: got %h expected %h", obs, expv(0)); end
    do_reset();
    send_bits(14'h2CE5, 1, 1, 0); finish_check(14'h2CE5, 1, 0, 0, 0);
    send_bits(14'h0001, 0, 1, 0); finish_check(14'h0001, 0, 1, 0, 0);
    n_cmp++; if (obs !== expv(0) || WORD !== 14'h0001 || OVRN !== 1'b0) begin n_bad++; $display("FAIL ack_in_check: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_framing;
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 1, 0, 0);
    send_bits(14'h3FFF, 1, 1, 0); m_frerr = 1;
    finish_check(14'h3FFF, 1, 0, 0, 0);
    n_cmp++; if (obs !== expv(0) || WORD !== 14'h3FFF) begin n_bad++; $display("FAIL framing: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (7) cyc(0, 1, 1, 0, 0);
    SIM_RST = 1; #1;
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_mid: got %h expected %h", obs, '0); end
    @(posedge SIM_CLK); #1; SIM_RST = 0; model_clear();
    send_bits(14'h1A5C, 1, 1, 1);
    finish_check(14'h1A5C, 1, 0, 0, 0);
    n_cmp++; if (obs !== expv(0)) begin n_bad++; $display("FAIL after_reset_word: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_start_samp;
    do_reset();
    cyc(1, 1, 1, 0, 0);
    send_bits(14'h0123, 1, 0, 0);
    finish_check(14'h0123, 1, 0, 0, 0);
    n_cmp++; if (obs !== expv(0) || WORD !== 14'h0123) begin n_bad++; $display("FAIL start_samp: got %h expected %h", obs, expv(0)); end
  endtask

  task automatic test_random;
    logic b2b, st, p, ack, clr, ws, isp, iack, iclr;
    logic [W-1:0] d;
    int k;
    b2b = 0;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      d = W'($urandom); p = 1'($urandom); ack = 1'($urandom);
      clr = $urandom_range(3, 0) == 0; ws = $urandom_range(2, 0) == 0; st = !b2b;
      if ($urandom_range(5, 0) == 0) begin
        k = $urandom_range(W, 0);
        if (!b2b) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < k; i++) cyc(0, 1, 1'($urandom), 0, 0);
        st = 1; m_frerr = 1;
      end
      send_bits(d, p, st, 2);
      n_cmp++; if ({WVALID, BUSY} !== {m_wv, 1'b1}) begin n_bad++; $display("FAIL rand_par n=%0d: got %b expected %b", n, {WVALID, BUSY}, {m_wv, 1'b1}); end
      finish_check(d, p, ack, clr, ws);
      n_cmp++; if (obs !== expv(ws)) begin n_bad++; $display("FAIL rand_word n=%0d: got %h expected %h", n, obs, expv(ws)); end
      b2b = ws;
      if (!ws) begin
        isp = 1'($urandom); iack = 1'($urandom); iclr = $urandom_range(3, 0) == 0;
        cyc(0, isp, 1'($urandom), iack, iclr);
        if (iack) m_wv = 0;
        if (iclr) begin m_perr = 0; m_ovrn = 0; m_frerr = 0; end
        n_cmp++; if (obs !== expv(0)) begin n_bad++; $display("FAIL rand_idle n=%0d: got %h expected %h", n, obs, expv(0)); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_good_word();
    test_bad_parity();
    test_overrun();
    test_framing();
    test_reset_mid();
    test_start_samp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
